// File: rtl/prbs_checker_pkg.sv
// Shared PRBS definitions: polynomial tap lookup and checker state encoding.
// The TX generator imports this package too, so both ends agree on polynomials.
package prbs_checker_pkg;

  localparam int unsigned PRBS_ORDER_DEF = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_LOCK,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Second tap of x^N + x^TAP + 1 for the standard ITU PRBS polynomials.
  function automatic int unsigned prbs_tap(input int unsigned order);
    case (order)
      7:       return 6;
      9:       return 5;
      15:      return 14;
      23:      return 18;
      31:      return 28;
      default: return order - 1;
    endcase
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Stream-in / status-out bundle between the RX datapath and the PRBS checker.
interface prbs_checker_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 start;
  logic                 in_valid;
  logic                 in_bit;
  logic                 locked;
  logic [CNT_WIDTH-1:0] bit_count;
  logic [CNT_WIDTH-1:0] err_count;
  logic                 sim_done;

  modport master (
    output start, in_valid, in_bit,
    input  locked, bit_count, err_count, sim_done
  );

  modport slave (
    input  start, in_valid, in_bit,
    output locked, bit_count, err_count, sim_done
  );
endinterface

// File: rtl/prbs_checker_lfsr.sv
// N-bit PRBS shift register; shifts either the received bit (self-sync) or its
// own prediction (free-running), and exposes the predicted next bit.
module prbs_lfsr
  import prbs_checker_pkg::*;
#(
  parameter int unsigned N   = PRBS_ORDER_DEF,
  parameter int unsigned TAP = prbs_tap(N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic self_feed,
  input  logic din,
  output logic pred
);
  logic [N-1:0] sr;

  assign pred = sr[N-1] ^ sr[TAP-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (en) begin
      sr <= {sr[N-2:0], (self_feed ? pred : din)};
    end
  end
endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: seeds from the stream, self-synchronises until
// LOCK_BITS consecutive predictions hit, then counts checked bits and errors.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int unsigned PRBS_ORDER = PRBS_ORDER_DEF,
  parameter int unsigned LOCK_BITS  = 32,
  parameter int unsigned TEST_BITS  = 65536,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input logic           clk,
  input logic           rst_n,
  prbs_checker_if.slave bus
);
  localparam int unsigned SW = $clog2(PRBS_ORDER + 1);
  localparam int unsigned MW = $clog2(LOCK_BITS + 1);
  localparam int unsigned TW = $clog2(TEST_BITS + 1);
  // Bit counter is kept wide enough to reach TEST_BITS even if CNT_WIDTH is narrower.
  localparam int unsigned BW = (TW > CNT_WIDTH) ? TW : CNT_WIDTH;

  state_t               state, state_nxt;
  logic [SW-1:0]        seed_cnt, seed_nxt;
  logic [MW-1:0]        match_cnt, match_nxt;
  logic [BW-1:0]        bits, bits_nxt;
  logic [CNT_WIDTH-1:0] errs, errs_nxt;
  logic                 locked_q, done_q;
  logic                 shift_en, self_feed, pred;

  prbs_lfsr #(
    .N   (PRBS_ORDER),
    .TAP (prbs_tap(PRBS_ORDER))
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (shift_en),
    .self_feed (self_feed),
    .din       (bus.in_bit),
    .pred      (pred)
  );

  always_comb begin
    state_nxt = state;
    seed_nxt  = seed_cnt;
    match_nxt = match_cnt;
    bits_nxt  = bits;
    errs_nxt  = errs;
    shift_en  = 1'b0;
    self_feed = 1'b0;
    if (bus.start) begin
      state_nxt = ST_SEED;
      seed_nxt  = '0;
      match_nxt = '0;
      bits_nxt  = '0;
      errs_nxt  = '0;
    end else if (bus.in_valid) begin
      unique case (state)
        ST_SEED: begin
          shift_en = 1'b1;
          if (seed_cnt == SW'(PRBS_ORDER - 1)) begin
            state_nxt = ST_LOCK;
            seed_nxt  = '0;
            match_nxt = '0;
          end else begin
            seed_nxt = seed_cnt + 1'b1;
          end
        end
        ST_LOCK: begin
          shift_en = 1'b1;
          if (bus.in_bit != pred) begin
            match_nxt = '0;
          end else if (match_cnt == MW'(LOCK_BITS - 1)) begin
            state_nxt = ST_CHECK;
          end else begin
            match_nxt = match_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          shift_en  = 1'b1;
          self_feed = 1'b1;
          bits_nxt  = bits + 1'b1;
          if (bus.in_bit != pred && errs != '1) begin
            errs_nxt = errs + 1'b1;
          end
          if (bits == BW'(TEST_BITS - 1)) begin
            state_nxt = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      seed_cnt  <= '0;
      match_cnt <= '0;
      bits      <= '0;
      errs      <= '0;
      locked_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      seed_cnt  <= seed_nxt;
      match_cnt <= match_nxt;
      bits      <= bits_nxt;
      errs      <= errs_nxt;
      locked_q  <= (state_nxt == ST_CHECK) || (state_nxt == ST_DONE);
      done_q    <= (state_nxt == ST_DONE);
    end
  end

  assign bus.locked    = locked_q;
  assign bus.sim_done  = done_q;
  assign bus.bit_count = bits[CNT_WIDTH-1:0];
  assign bus.err_count = errs;
endmodule
